bpred_pht_init_ctrl: RTL and testbench

Controller for the write port of the branch-direction pattern history table (PHT). After reset, and on request, it walks every PHT entry and writes a known counter state. At all other times it passes the Writeback-stage direction updates through to the single PHT write port. It sits between the direction predictor's update logic and the PHT two-port RAM write port, and flags the IFU when predictions are not yet trustworthy.

---
 rtl/bpred_pht_init_ctrl.sv | 92 +++++++++
 tb/tb_bpred_pht_init_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bpred_pht_init_ctrl.sv
// PHT write-port controller: sweeps every entry to INIT_STATE after reset or on request,
// otherwise forwards Writeback direction updates to the single PHT write port.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | port carries direction updates; predictions trusted
// S_CLEAR | controller owns the port, writing INIT_STATE to entry cnt_q
module bpred_pht_init_ctrl #(
    parameter int         k          = 10,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         InitReq,
    input  logic         StallW,
    input  logic         FlushW,
    input  logic         UpdWeM,
    input  logic [k-1:0] UpdIndexM,
    input  logic [1:0]   UpdDataM,
    output logic         PHTWe,
    output logic [k-1:0] PHTWa,
    output logic [1:0]   PHTWd,
    output logic         InitBusy,
    output logic         InitDone,
    output logic         PredValidF,
    output logic         UpdDropped
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [k-1:0] CNT_ONE = k'(1);
    localparam logic [k-1:0] CNT_MAX = '1;

    state_t       state_q, state_d;
    logic [k-1:0] cnt_q, cnt_d;
    logic         init_done_q, init_done_d;
    logic         upd_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign upd_ok = UpdWeM & ~StallW & ~FlushW;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = 1'b0;
        PHTWe       = 1'b0;
        PHTWa       = UpdIndexM;
        PHTWd       = UpdDataM;
        UpdDropped  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                PHTWe      = 1'b1;
                PHTWa      = cnt_q;
                PHTWd      = INIT_STATE;
                UpdDropped = upd_ok;
                // A fresh request restarts the sweep, including on its last entry.
                if (InitReq) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_MAX) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            default: begin
                PHTWe = upd_ok;
                if (InitReq) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign InitBusy   = (state_q == S_CLEAR);
    assign InitDone   = init_done_q;
    assign PredValidF = ~InitBusy;

endmodule

// File: tb/tb_bpred_pht_init_ctrl.sv
// Self-checking bench for bpred_pht_init_ctrl (k=4): directed scenarios plus random traffic
// checked against a queue-of-pending-clear-addresses reference model and a shadow PHT.
module tb_bpred_pht_init_ctrl;

    localparam int         K     = 4;
    localparam int         DEPTH = 1 << K;
    localparam logic [1:0] INIT  = 2'b01;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         InitReq = 1'b0, StallW = 1'b0, FlushW = 1'b0, UpdWeM = 1'b0;
    logic [K-1:0] UpdIndexM = '0;
    logic [1:0]   UpdDataM = '0;
    logic         PHTWe, InitBusy, InitDone, PredValidF, UpdDropped;
    logic [K-1:0] PHTWa;
    logic [1:0]   PHTWd;

    bpred_pht_init_ctrl #(.k(K), .INIT_STATE(INIT)) dut (
        .clk(clk), .reset(reset), .InitReq(InitReq), .StallW(StallW), .FlushW(FlushW),
        .UpdWeM(UpdWeM), .UpdIndexM(UpdIndexM), .UpdDataM(UpdDataM),
        .PHTWe(PHTWe), .PHTWa(PHTWa), .PHTWd(PHTWd), .InitBusy(InitBusy),
        .InitDone(InitDone), .PredValidF(PredValidF), .UpdDropped(UpdDropped)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         clr_q[$];
    bit         done_flag = 1'b0;
    logic [1:0] model_mem[DEPTH];
    logic [1:0] dut_mem[DEPTH];
    int         done_seen = 0;
    int         clear_writes = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_start_clear();
        clr_q.delete();
        for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
    endfunction

    // Called at a negedge; returns at the next negedge.
    task automatic step(input bit ireq, input bit we, input int idx, input int dat,
                        input bit stall, input bit flush);
        bit         busy, upd_ok, e_we;
        int         e_wa;
        logic [1:0] e_wd;
        InitReq   = ireq;
        UpdWeM    = we;
        UpdIndexM = K'(idx);
        UpdDataM  = 2'(dat);
        StallW    = stall;
        FlushW    = flush;
        #1;
        busy   = (clr_q.size() != 0);
        upd_ok = we && !stall && !flush;
        if (busy) begin
            e_we = 1'b1; e_wa = clr_q[0]; e_wd = INIT;
        end else begin
            e_we = upd_ok; e_wa = idx; e_wd = 2'(dat);
        end
        chk_eq("busy",    32'(InitBusy),   32'(busy));
        chk_eq("pvalid",  32'(PredValidF), 32'(!busy));
        chk_eq("we",      32'(PHTWe),      32'(e_we));
        if (e_we) begin
            chk_eq("wa", 32'(PHTWa), 32'(e_wa));
            chk_eq("wd", 32'(PHTWd), 32'(e_wd));
        end
        chk_eq("done",    32'(InitDone),   32'(done_flag));
        chk_eq("dropped", 32'(UpdDropped), 32'(busy && upd_ok));
        if (PHTWe === 1'b1) dut_mem[PHTWa] = PHTWd;
        if (InitDone === 1'b1) done_seen++;
        if (InitBusy === 1'b1 && PHTWe === 1'b1) clear_writes++;
        if (e_we) model_mem[e_wa] = e_wd;
        @(posedge clk);
        done_flag = 1'b0;
        if (busy) begin
            void'(clr_q.pop_front());
            if (ireq) model_start_clear();
            else if (clr_q.size() == 0) done_flag = 1'b1;
        end else if (ireq) begin
            model_start_clear();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Asserts reset 2 time units after a negedge, away from any clock edge.
    task automatic apply_reset(input int n);
        InitReq = 1'b0; UpdWeM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_eq("rst_busy",    32'(InitBusy),   32'd1);
        chk_eq("rst_pvalid",  32'(PredValidF), 32'd0);
        chk_eq("rst_we",      32'(PHTWe),      32'd1);
        chk_eq("rst_wa",      32'(PHTWa),      32'd0);
        chk_eq("rst_wd",      32'(PHTWd),      32'(INIT));
        chk_eq("rst_done",    32'(InitDone),   32'd0);
        chk_eq("rst_dropped", 32'(UpdDropped), 32'd0);
        model_start_clear();
        done_flag    = 1'b0;
        model_mem[0] = INIT;
        dut_mem[0]   = INIT;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic compare_mems(input string tag);
        for (int i = 0; i < DEPTH; i++) chk_eq(tag, 32'(dut_mem[i]), 32'(model_mem[i]));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 2'b00;
            dut_mem[i]   = 2'b00;
        end

        // Power-up clear
        apply_reset(3);
        done_seen = 0; clear_writes = 0;
        idle(16);
        chk_eq("t1_writes", 32'(clear_writes), 32'd16);
        chk_eq("t1_early_done", 32'(done_seen), 32'd0);
        idle(2);
        chk_eq("t1_done_once", 32'(done_seen), 32'd1);
        compare_mems("t1_mem");

        // Pass-through, stalled and flushed updates
        step(1'b0, 1'b1, 5, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5, 3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5, 3, 1'b0, 1'b1);

        // InitReq together with an eligible update
        done_seen = 0; clear_writes = 0;
        step(1'b1, 1'b1, 9, 2, 1'b0, 1'b0);
        idle(17);
        chk_eq("t3_writes", 32'(clear_writes), 32'd16);
        chk_eq("t3_done_once", 32'(done_seen), 32'd1);

        // Restart at Cnt=7
        done_seen = 0; clear_writes = 0;
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(17);
        chk_eq("t4_writes", 32'(clear_writes), 32'd24);
        chk_eq("t4_done_once", 32'(done_seen), 32'd1);

        // Dropped update at Cnt=10
        step(1'b0, 1'b1, 3, 3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(10);
        step(1'b0, 1'b1, 3, 3, 1'b0, 1'b0);
        idle(6);
        chk_eq("t5_entry3", 32'(dut_mem[3]), 32'(INIT));
        compare_mems("t5_mem");

        // Async reset at Cnt=12
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(12);
        apply_reset(2);
        done_seen = 0; clear_writes = 0;
        idle(16);
        chk_eq("t6_writes", 32'(clear_writes), 32'd16);
        chk_eq("t6_no_early_done", 32'(done_seen), 32'd0);
        idle(1);
        chk_eq("t6_done_once", 32'(done_seen), 32'd1);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset(1 + int'($urandom_range(0, 2)));
            end else begin
                step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end
        idle(40);
        compare_mems("rand_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
